adder_arbiter: RTL and testbench
================================

ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/sum width in bits.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have ports req0_valid / req1_valid  input  1  requester n presents operands.
REQ-005 SHALL have ports req0_a, req0_b / req1_a, req1_b  input  WIDTH  requester n operands.
REQ-006 SHALL have ports req0_ready / req1_ready  output  1  requester n operands accepted this cycle.
REQ-007 SHALL have port rsp_valid  output  1  result held and valid.
REQ-008 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-009 SHALL have port rsp_sum  output  WIDTH  registered sum, modulo 2^WIDTH.
REQ-010 SHALL have port rsp_carry  output  1  registered carry-out of the addition.
REQ-011 SHALL have port rsp_id  output  1  index of the requester that owns the result.

Function
REQ-012 SHALL implement two states, IDLE and RESP.
REQ-013 In IDLE with no reqN_valid high: SHALL stay in IDLE, both readies low.
REQ-014 In IDLE with exactly one reqN_valid high: SHALL grant that requester.
REQ-015 In IDLE with both valid: SHALL grant the requester not granted last (round-robin via last_grant register).
REQ-016 reqN_ready SHALL be combinational: high only in IDLE, only for the granted requester, only while its valid is high.
REQ-017 The transfer takes place in the cycle where reqN_valid and reqN_ready are both high; at that edge SHALL register sum, carry and id, set last_grant to N, and enter RESP.
REQ-018 Latency SHALL be one cycle: rsp_valid high in the cycle after the transfer.
REQ-019 In RESP: rsp_valid SHALL be high, rsp_sum/rsp_carry/rsp_id SHALL stay stable, and both readies SHALL be low.
REQ-020 In RESP with rsp_ready high: SHALL return to IDLE at that edge; no new request is accepted in the same cycle (max throughput one result per 2 cycles).
REQ-021 In RESP with rsp_ready low: SHALL hold indefinitely (backpressure); requesters stall.
REQ-022 Arithmetic: {rsp_carry, rsp_sum} SHALL equal a + b computed at WIDTH+1 bits; wrap-around is reported only via rsp_carry.
REQ-023 Operand changes on a non-granted or non-ready port SHALL have no effect on state or outputs.
REQ-024 A requester that drops valid before being granted SHALL lose its slot; no request is queued.

Reset
REQ-025 While rst_n is low at a clock edge, SHALL enter IDLE, with rsp_valid=0, rsp_sum=0, rsp_carry=0, rsp_id=0, last_grant=1 (requester 0 wins the first tie).
REQ-026 Reset in RESP SHALL discard the held result; rsp_valid SHALL be low from the following cycle.
REQ-027 reqN_ready SHALL be low during any cycle in which rst_n is low.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE, RESP), the requester-id constants (REQ0=0, REQ1=1) and the default WIDTH.
REQ-029 SHALL instantiate exactly one existing ripple adder sub-module, adder (ports a, b, s, c), fed by a grant-controlled operand mux; no second adder.
REQ-030 All outputs except reqN_ready SHALL be driven directly from registers.

Verification
REQ-031 Req0 only, a=1011, b=1001, rsp_ready=1: req0_ready high in cycle 0; next cycle rsp_valid=1, rsp_sum=0100, rsp_carry=1, rsp_id=0.
REQ-032 Both valid from reset, req0 0011+0100, req1 1111+0001, rsp_ready=1: first result 0111/c0/id0, then 0000/c1/id1; grants alternate while both stay valid.
REQ-033 Backpressure: result pending, rsp_ready=0 for 5 cycles with new req1 valid: outputs stable, req1_ready low throughout; on rsp_ready=1, return to IDLE and accept req1 the next cycle.
REQ-034 Reset mid-RESP: rst_n low for one edge: rsp_valid=0, rsp_sum=0, rsp_carry=0 next cycle; after release, a tie grants req0.
REQ-035 Random regression over 1000 transfers with random valids and rsp_ready: every result equals a+b of its granted requester, with no loss or duplication per requester and no starvation.

Source files
------------

// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the two-requester adder arbiter: state encoding,
// requester ids and the default operand width.
package adder_arbiter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/adder_arbiter_adder.sv
// Plain ripple-carry adder: {c, s} = a + b, one full-adder cell per bit.
module adder #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] s,
  output logic             c
);

  logic [WIDTH:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    assign s[i]       = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign c = carry[WIDTH];

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter that accepts one operand pair from two requesters,
// adds it through a single shared adder and holds the result until consumed.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_carry,
  output logic             rsp_id,
  output state_t           state_dbg
);

  state_t           state;
  logic             last_grant;
  logic             grant;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             accept;

  // On a tie the requester that did not win last time is served.
  always_comb begin
    grant = REQ0;
    if (req0_valid && req1_valid) begin
      grant = ~last_grant;
    end else if (req1_valid) begin
      grant = REQ1;
    end
  end

  // Handshake: a transfer happens on an edge where valid and ready are both
  // high; ready never depends on anything but state, grant, valid and reset.
  assign req0_ready = rst_n && (state == IDLE) && (grant == REQ0) && req0_valid;
  assign req1_ready = rst_n && (state == IDLE) && (grant == REQ1) && req1_valid;
  assign accept     = req0_ready || req1_ready;

  assign op_a = (grant == REQ1) ? req1_a : req0_a;
  assign op_b = (grant == REQ1) ? req1_b : req0_b;

  adder #(.WIDTH(WIDTH)) u_adder (
    .a (op_a),
    .b (op_b),
    .s (sum),
    .c (carry)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= REQ1;
      rsp_valid  <= 1'b0;
      rsp_sum    <= '0;
      rsp_carry  <= 1'b0;
      rsp_id     <= REQ0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state      <= RESP;
            last_grant <= grant;
            rsp_valid  <= 1'b1;
            rsp_sum    <= sum;
            rsp_carry  <= carry;
            rsp_id     <= grant;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state     <= IDLE;
            rsp_valid <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter: a reference model predicts readies and results,
// a scoreboard queue holds expected {id, carry, sum}, directed tasks add
// explicit spot checks on top.
module tb_adder_arbiter;
  import adder_arbiter_pkg::*;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         req0_valid, req1_valid;
  logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
  logic         req0_ready, req1_ready;
  logic         rsp_valid, rsp_ready;
  logic [W-1:0] rsp_sum;
  logic         rsp_carry, rsp_id;
  state_t       state_dbg;

  int total = 0;
  int bad   = 0;

  logic [W+1:0] exp_q[$];
  logic         armed = 1'b0;
  logic         m_resp = 1'b0;
  logic         m_last = 1'b1;
  logic         fire0 = 1'b0, fire1 = 1'b0;
  logic         e0, e1, g;
  logic [W+1:0] got;
  logic [W:0]   s0, s1;
  int           acc0 = 0, acc1 = 0, got0 = 0, got1 = 0;

  adder_arbiter #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_carry  (rsp_carry),
    .rsp_id     (rsp_id),
    .state_dbg  (state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: inputs are stable around the falling edge.
  always @(negedge clk) begin
    fire0 = 1'b0;
    fire1 = 1'b0;
    if (armed) begin
      g  = (req0_valid && req1_valid) ? ~m_last : req1_valid;
      e0 = rst_n && !m_resp && req0_valid && (g == 1'b0);
      e1 = rst_n && !m_resp && req1_valid && (g == 1'b1);
      total += 2;
      if (req0_ready !== e0) begin
        bad++;
        $display("FAIL sb_req0_ready t=%0t got=%b exp=%b", $time, req0_ready, e0);
      end
      if (req1_ready !== e1) begin
        bad++;
        $display("FAIL sb_req1_ready t=%0t got=%b exp=%b", $time, req1_ready, e1);
      end
      s0 = {1'b0, req0_a} + {1'b0, req0_b};
      s1 = {1'b0, req1_a} + {1'b0, req1_b};
      fire0 = e0;
      fire1 = e1;
      if (e0) begin exp_q.push_back({1'b0, s0}); acc0++; end
      if (e1) begin exp_q.push_back({1'b1, s1}); acc1++; end
      total++;
      if (m_resp) begin
        got = {rsp_id, rsp_carry, rsp_sum};
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_rsp t=%0t got=%b exp=<none queued>", $time, got);
        end else begin
          if (rsp_valid !== 1'b1 || got !== exp_q[0]) begin
            bad++;
            $display("FAIL sb_rsp t=%0t got=v%b %b exp=v1 %b", $time, rsp_valid, got, exp_q[0]);
          end
          if (rsp_ready && rst_n) begin
            if (exp_q[0][W+1]) got1++; else got0++;
            void'(exp_q.pop_front());
          end
        end
      end else if (rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL sb_rsp_idle t=%0t got=%b exp=0", $time, rsp_valid);
      end
    end
  end

  // Reference model state update.
  always @(posedge clk) begin
    if (!rst_n) begin
      m_resp = 1'b0;
      m_last = 1'b1;
      exp_q.delete();
    end else if (fire0 || fire1) begin
      m_resp = 1'b1;
      m_last = fire1;
    end else if (m_resp && rsp_ready) begin
      m_resp = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    req0_a = 4'h3; req0_b = 4'h4; req1_a = 4'hf; req1_b = 4'h1;
    tick();
    armed = 1'b1;
    @(negedge clk);
    total += 3;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready);
    end
    if ({rsp_valid, rsp_id, rsp_carry, rsp_sum} !== 7'b0) begin
      bad++; $display("FAIL reset_rsp got=%b exp=0000000", {rsp_valid, rsp_id, rsp_carry, rsp_sum});
    end
    if (state_dbg !== IDLE) begin
      bad++; $display("FAIL reset_state got=%b exp=%b", state_dbg, IDLE);
    end
    tick();
    rst_n = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_single();
    apply_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 4'b1011; req0_b = 4'b1001;
    @(negedge clk);
    total++;
    if (req0_ready !== 1'b1) begin
      bad++; $display("FAIL single_ready got=%b exp=1", req0_ready);
    end
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({rsp_valid, rsp_id, rsp_carry, rsp_sum} !== 7'b1_0_1_0100) begin
      bad++; $display("FAIL single_rsp got=%b exp=1010100", {rsp_valid, rsp_id, rsp_carry, rsp_sum});
    end
    tick();
  endtask

  task automatic test_tie();
    apply_reset();
    rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_a = 4'b0011; req0_b = 4'b0100;
    req1_valid = 1'b1; req1_a = 4'b1111; req1_b = 4'b0001;
    @(negedge clk);
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++; $display("FAIL tie_grant0 got=%b%b exp=10", req0_ready, req1_ready);
    end
    tick();
    @(negedge clk);
    total++;
    if ({rsp_valid, rsp_id, rsp_carry, rsp_sum} !== 7'b1_0_0_0111) begin
      bad++; $display("FAIL tie_rsp0 got=%b exp=1000111", {rsp_valid, rsp_id, rsp_carry, rsp_sum});
    end
    tick();
    @(negedge clk);
    total++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      bad++; $display("FAIL tie_grant1 got=%b%b exp=01", req0_ready, req1_ready);
    end
    tick();
    @(negedge clk);
    total++;
    if ({rsp_valid, rsp_id, rsp_carry, rsp_sum} !== 7'b1_1_1_0000) begin
      bad++; $display("FAIL tie_rsp1 got=%b exp=1110000", {rsp_valid, rsp_id, rsp_carry, rsp_sum});
    end
    tick();
    @(negedge clk);
    total++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++; $display("FAIL tie_grant0_again got=%b%b exp=10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'b0110; req0_b = 4'b0001;
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 4'b0010; req1_b = 4'b0011;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({rsp_valid, rsp_id, rsp_carry, rsp_sum, req1_ready} !== 8'b1_0_0_0111_0) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%b exp=10001110", i, {rsp_valid, rsp_id, rsp_carry, rsp_sum, req1_ready});
      end
      tick();
      req0_a = W'($urandom_range(0, 15));
      req0_b = W'($urandom_range(0, 15));
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    total++;
    if (req1_ready !== 1'b0) begin
      bad++; $display("FAIL bp_release_ready got=%b exp=0", req1_ready);
    end
    tick();
    @(negedge clk);
    total++;
    if (req1_ready !== 1'b1) begin
      bad++; $display("FAIL bp_accept got=%b exp=1", req1_ready);
    end
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({rsp_valid, rsp_id, rsp_carry, rsp_sum} !== 7'b1_1_0_0101) begin
      bad++; $display("FAIL bp_rsp got=%b exp=1100101", {rsp_valid, rsp_id, rsp_carry, rsp_sum});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 4'b1111; req0_b = 4'b1111;
    tick();
    req0_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req0_valid = 1'b1; req0_a = 4'b0001; req0_b = 4'b0001;
    req1_valid = 1'b1; req1_a = 4'b0010; req1_b = 4'b0010;
    @(negedge clk);
    total += 2;
    if ({rsp_valid, rsp_carry, rsp_sum} !== 6'b0) begin
      bad++; $display("FAIL rstmid_rsp got=%b exp=000000", {rsp_valid, rsp_carry, rsp_sum});
    end
    if ({req0_ready, req1_ready} !== 2'b10) begin
      bad++; $display("FAIL rstmid_tie got=%b%b exp=10", req0_ready, req1_ready);
    end
    rsp_ready = 1'b1;
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_drop();
    rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 4'b0101; req1_b = 4'b0101;
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 4'b0111; req0_b = 4'b0001;
    tick();
    tick();
    req0_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    tick();
    @(negedge clk);
    total++;
    if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin
      bad++; $display("FAIL drop_no_queue got=%b exp=000", {rsp_valid, req0_ready, req1_ready});
    end
    tick();
  endtask

  task automatic test_random();
    int cyc;
    int base;
    acc0 = 0; acc1 = 0; got0 = 0; got1 = 0;
    cyc = 0;
    base = 0;
    while ((acc0 + acc1) < 1000 && cyc < 30000) begin
      rsp_ready = 1'($urandom_range(0, 1));
      if (!req0_valid || fire0) begin
        req0_valid = 1'($urandom_range(0, 1));
        req0_a = W'($urandom_range(0, 15)); req0_b = W'($urandom_range(0, 15));
      end
      if (!req1_valid || fire1) begin
        req1_valid = 1'($urandom_range(0, 1));
        req1_a = W'($urandom_range(0, 15)); req1_b = W'($urandom_range(0, 15));
      end
      tick();
      cyc++;
    end
    total++;
    if ((acc0 + acc1) < 1000) begin
      bad++; $display("FAIL rand_budget transfers=%0d required=1000", acc0 + acc1);
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    total += 4;
    if (exp_q.size() != base) begin
      bad++; $display("FAIL rand_drain pending=%0d exp=0", exp_q.size());
    end
    if (got0 != acc0) begin
      bad++; $display("FAIL rand_req0_count got=%0d exp=%0d", got0, acc0);
    end
    if (got1 != acc1) begin
      bad++; $display("FAIL rand_req1_count got=%0d exp=%0d", got1, acc1);
    end
    if (acc0 < 100 || acc1 < 100) begin
      bad++; $display("FAIL rand_starvation req0=%0d req1=%0d exp>=100 each", acc0, acc1);
    end
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_reset_mid();
    test_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
